// File: rtl/quote_order_gen_if.sv
// Quote input and order output bundle for quote_order_gen.
// The slave modport is the generator's view; master is the trading logic / consumer side.
interface quote_order_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4
);
  localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  logic [DATA_WIDTH-1:0] i_buy_price;
  logic [DATA_WIDTH-1:0] i_sell_price;
  logic [SW-1:0]         i_stock_id;
  logic                  i_data_valid;
  logic                  o_order_valid;
  logic                  i_order_ready;
  logic                  o_order_side;
  logic                  o_order_type;
  logic [SW-1:0]         o_order_stock_id;
  logic [DATA_WIDTH-1:0] o_order_price;
  logic                  o_fifo_full;
  logic [15:0]           o_dropped_count;

  modport slave (
    input  i_buy_price, i_sell_price, i_stock_id, i_data_valid, i_order_ready,
    output o_order_valid, o_order_side, o_order_type, o_order_stock_id,
           o_order_price, o_fifo_full, o_dropped_count
  );

  modport master (
    output i_buy_price, i_sell_price, i_stock_id, i_data_valid, i_order_ready,
    input  o_order_valid, o_order_side, o_order_type, o_order_stock_id,
           o_order_price, o_fifo_full, o_dropped_count
  );
endinterface

// File: rtl/quote_order_gen.sv
// Turns per-stock bid/ask quotes into NEW/REPLACE order messages whenever a side's price
// changes, buffering them in a FIFO and counting quotes that could not be buffered.
module quote_order_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  quote_order_gen_if.slave bus
);
  localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  side;
    logic                  typ;
    logic [SW-1:0]         stock_id;
    logic [DATA_WIDTH-1:0] price;
  } entry_t;

  entry_t                mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  valid_r;
  logic                  full_r;
  logic [15:0]           dropped_r;
  logic [DATA_WIDTH-1:0] buy_last_r  [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] sell_last_r [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] buy_act_r;
  logic [NUM_STOCKS-1:0] sell_act_r;

  logic          buy_cand_s;
  logic          sell_cand_s;
  logic          accept_s;
  logic          push_buy_s;
  logic          push_sell_s;
  logic          drop_s;
  logic          pop_s;
  logic [CW-1:0] count_next_s;
  logic [PW-1:0] sell_slot_s;
  entry_t        buy_entry_s;
  entry_t        sell_entry_s;
  entry_t        head_s;

  // Candidate generation, acceptance against the registered count, and push/pop bookkeeping.
  always_comb begin
    buy_cand_s  = 1'b0;
    sell_cand_s = 1'b0;
    if (bus.i_data_valid) begin
      buy_cand_s  = (bus.i_buy_price != '0) &&
                    (!buy_act_r[bus.i_stock_id] || (bus.i_buy_price != buy_last_r[bus.i_stock_id]));
      sell_cand_s = (bus.i_sell_price != '0) &&
                    (!sell_act_r[bus.i_stock_id] || (bus.i_sell_price != sell_last_r[bus.i_stock_id]));
    end else begin
      buy_cand_s  = 1'b0;
      sell_cand_s = 1'b0;
    end
    accept_s     = (CW'(FIFO_DEPTH) - count_r) >= CW'(2);
    push_buy_s   = buy_cand_s && accept_s;
    push_sell_s  = sell_cand_s && accept_s;
    drop_s       = (buy_cand_s || sell_cand_s) && !accept_s;
    pop_s        = valid_r && bus.i_order_ready;
    count_next_s = count_r + CW'(push_buy_s) + CW'(push_sell_s) - CW'(pop_s);
    sell_slot_s  = push_buy_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;

    buy_entry_s.side      = 1'b0;
    buy_entry_s.typ       = buy_act_r[bus.i_stock_id];
    buy_entry_s.stock_id  = bus.i_stock_id;
    buy_entry_s.price     = bus.i_buy_price;
    sell_entry_s.side     = 1'b1;
    sell_entry_s.typ      = sell_act_r[bus.i_stock_id];
    sell_entry_s.stock_id = bus.i_stock_id;
    sell_entry_s.price    = bus.i_sell_price;
  end

  // Order FIFO storage, pointers, count and registered status flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      valid_r   <= 1'b0;
      full_r    <= 1'b0;
      dropped_r <= 16'h0000;
    end else begin
      if (push_buy_s) begin
        mem_r[wr_ptr_r] <= buy_entry_s;
      end
      if (push_sell_s) begin
        mem_r[sell_slot_s] <= sell_entry_s;
      end
      wr_ptr_r <= wr_ptr_r + PW'(push_buy_s) + PW'(push_sell_s);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != CW'(0));
      full_r  <= (count_next_s == CW'(FIFO_DEPTH));
      if (drop_s && (dropped_r != 16'hFFFF)) begin
        dropped_r <= dropped_r + 16'h0001;
      end
    end
  end

  // Last-sent price table; only sides actually pushed are updated.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_STOCKS; i++) begin
        buy_last_r[i]  <= '0;
        sell_last_r[i] <= '0;
      end
      buy_act_r  <= '0;
      sell_act_r <= '0;
    end else begin
      if (push_buy_s) begin
        buy_last_r[bus.i_stock_id] <= bus.i_buy_price;
        buy_act_r[bus.i_stock_id]  <= 1'b1;
      end
      if (push_sell_s) begin
        sell_last_r[bus.i_stock_id] <= bus.i_sell_price;
        sell_act_r[bus.i_stock_id]  <= 1'b1;
      end
    end
  end

  assign head_s               = mem_r[rd_ptr_r];
  assign bus.o_order_valid    = valid_r;
  assign bus.o_order_side     = head_s.side;
  assign bus.o_order_type     = head_s.typ;
  assign bus.o_order_stock_id = head_s.stock_id;
  assign bus.o_order_price    = head_s.price;
  assign bus.o_fifo_full      = full_r;
  assign bus.o_dropped_count  = dropped_r;
endmodule

// File: tb/tb_quote_order_gen.sv
// Directed plus randomized bench for quote_order_gen, checked against a queue-based order model.
module tb_quote_order_gen;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int FD = 8;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  quote_order_gen_if #(.DATA_WIDTH(DW), .NUM_STOCKS(NS)) bus ();
  quote_order_gen #(.DATA_WIDTH(DW), .NUM_STOCKS(NS), .FIFO_DEPTH(FD)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  typedef struct {
    logic        side;
    logic        typ;
    logic [1:0]  id;
    logic [31:0] price;
  } ord_t;

  ord_t        q[$];
  logic [31:0] last_p [2][NS];
  bit          act    [2][NS];
  int unsigned drops;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    drops = 0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < NS; k++) begin
        last_p[s][k] = 32'd0;
        act[s][k]    = 1'b0;
      end
  endtask

  function automatic bit wants(input int sd, input logic [1:0] id, input logic [31:0] p);
    return (p != 32'd0) && (!act[sd][id] || (p != last_p[sd][id]));
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.o_order_valid), 64'(q.size() != 0));
    chk({tag, "_full"}, 64'(bus.o_fifo_full), 64'(q.size() == FD));
    chk({tag, "_drops"}, 64'(bus.o_dropped_count), 64'(drops));
    if (q.size() != 0) begin
      chk({tag, "_side"}, 64'(bus.o_order_side), 64'(q[0].side));
      chk({tag, "_type"}, 64'(bus.o_order_type), 64'(q[0].typ));
      chk({tag, "_id"}, 64'(bus.o_order_stock_id), 64'(q[0].id));
      chk({tag, "_price"}, 64'(bus.o_order_price), 64'(q[0].price));
    end
  endtask

  // One clock: drive inputs, advance the model with the pre-edge view, then check after the edge.
  task automatic step(input string tag, input bit v, input logic [1:0] id,
                      input logic [31:0] b, input logic [31:0] s, input bit rdy);
    bit bw, sw, pop;
    ord_t o;
    bus.i_data_valid  = v;
    bus.i_stock_id    = id;
    bus.i_buy_price   = b;
    bus.i_sell_price  = s;
    bus.i_order_ready = rdy;
    @(posedge i_clk);
    bw  = v && wants(0, id, b);
    sw  = v && wants(1, id, s);
    pop = rdy && (q.size() != 0);
    if (bw || sw) begin
      if (FD - q.size() >= 2) begin
        if (bw) begin
          o.side = 1'b0; o.typ = act[0][id]; o.id = id; o.price = b;
          q.push_back(o);
          last_p[0][id] = b; act[0][id] = 1'b1;
        end
        if (sw) begin
          o.side = 1'b1; o.typ = act[1][id]; o.id = id; o.price = s;
          q.push_back(o);
          last_p[1][id] = s; act[1][id] = 1'b1;
        end
      end else if (drops != 32'hFFFF) begin
        drops++;
      end
    end
    if (pop) void'(q.pop_front());
    #1;
    check_outputs(tag);
    bus.i_data_valid = 1'b0;
  endtask

  initial begin
    bus.i_data_valid  = 1'b0;
    bus.i_stock_id    = 2'd0;
    bus.i_buy_price   = 32'd0;
    bus.i_sell_price  = 32'd0;
    bus.i_order_ready = 1'b0;
    model_clear();
    #3;
    chk("rst_valid", 64'(bus.o_order_valid), 64'd0);
    chk("rst_full", 64'(bus.o_fifo_full), 64'd0);
    chk("rst_drops", 64'(bus.o_dropped_count), 64'd0);
    chk("rst_price", 64'(bus.o_order_price), 64'd0);
    chk("rst_side_type", 64'({bus.o_order_side, bus.o_order_type}), 64'd0);
    chk("rst_id", 64'(bus.o_order_stock_id), 64'd0);
    #9 i_reset_n = 1'b1;

    // Basic two-sided quote, then dedupe and single-side replace.
    step("q1", 1'b1, 2'd2, 32'd100, 32'd105, 1'b1);
    chk("q1_buy_new", 64'({bus.o_order_side, bus.o_order_type, bus.o_order_price}), {32'd0, 2'b00, 32'd100});
    step("q1b", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    chk("q1_sell_new", 64'({bus.o_order_side, bus.o_order_type, bus.o_order_price}), {32'd0, 2'b10, 32'd105});
    step("q1c", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    step("dup", 1'b1, 2'd2, 32'd100, 32'd105, 1'b1);
    chk("dup_none", 64'(bus.o_order_valid), 64'd0);
    step("rep", 1'b1, 2'd2, 32'd100, 32'd106, 1'b1);
    chk("rep_sell", 64'({bus.o_order_side, bus.o_order_type, bus.o_order_price}), {32'd0, 2'b11, 32'd106});
    step("rep_b", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    step("s1", 1'b1, 2'd1, 32'd0, 32'd50, 1'b1);
    step("s1_b", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    step("zero", 1'b1, 2'd1, 32'd0, 32'd0, 1'b1);

    // Fill with backpressure, drop, drain two, retry.
    step("f0", 1'b1, 2'd0, 32'd10, 32'd11, 1'b0);
    step("f1", 1'b1, 2'd1, 32'd20, 32'd21, 1'b0);
    step("f2", 1'b1, 2'd2, 32'd30, 32'd31, 1'b0);
    step("f3", 1'b1, 2'd3, 32'd40, 32'd41, 1'b0);
    chk("full_flag", 64'(bus.o_fifo_full), 64'd1);
    step("drop", 1'b1, 2'd0, 32'd12, 32'd13, 1'b0);
    chk("drop_count", 64'(bus.o_dropped_count), 64'd1);
    step("dr0", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    step("dr1", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    step("retry", 1'b1, 2'd0, 32'd12, 32'd13, 1'b0);

    // Stream across pointer wrap with toggling ready.
    for (int i = 0; i < 24; i++)
      step("wrap", 1'b1, 2'(i), 32'(200 + i), 32'(300 + i), 1'(i % 2));
    for (int i = 0; i < 12; i++)
      step("wrap_drain", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);

    // Mid-operation reset with three buffered orders.
    step("pre_rst0", 1'b1, 2'd2, 32'd500, 32'd501, 1'b0);
    step("pre_rst1", 1'b1, 2'd3, 32'd0, 32'd502, 1'b0);
    #2 i_reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.o_order_valid), 64'd0);
    chk("midrst_drops", 64'(bus.o_dropped_count), 64'd0);
    model_clear();
    #2 i_reset_n = 1'b1;
    step("post_rst", 1'b1, 2'd2, 32'd500, 32'd501, 1'b1);
    chk("post_rst_new", 64'(bus.o_order_type), 64'd0);
    step("post_rst_b", 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b, s;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4));
      s = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(5, 8));
      step("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), b, s,
           1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
